ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Define PS2_TX_TIMEOUT_EN to add a device-clock watchdog in START/BITS/ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        ACK,
        WAIT_IDLE
    } state_t;

    // One counter serves the inhibit interval and, when enabled, the watchdog.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_DAT  = CNT_W'(INHIBIT_CYCLES - 2);

    state_t           state_reg;
    logic [1:0]       clk_sync_reg;
    logic [1:0]       dat_sync_reg;
    logic             clk_prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       bit_cnt_reg;
    logic [8:0]       shift_reg;

    logic clk_s;
    logic dat_s;
    logic fall;

    assign clk_s = clk_sync_reg[1];
    assign dat_s = dat_sync_reg[1];
    assign fall  = clk_prev_reg & ~clk_s;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic watch_active;
    logic timeout;
    assign watch_active = (state_reg == START) || (state_reg == BITS) || (state_reg == ACK);
    assign timeout      = watch_active && !fall && (cnt_reg == WD_LAST);
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            clk_sync_reg <= 2'b11;
            dat_sync_reg <= 2'b11;
            clk_prev_reg <= 1'b1;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            ps2_clk_oe   <= 1'b0;
            ps2_dat_oe   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[0], ps2_clk_in};
            dat_sync_reg <= {dat_sync_reg[0], ps2_dat_in};
            clk_prev_reg <= clk_s;
            done         <= 1'b0;
            error        <= 1'b0;

`ifdef PS2_TX_TIMEOUT_EN
            if (timeout) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                busy       <= 1'b0;
                error      <= 1'b1;
                state_reg  <= IDLE;
            end else
`endif
            begin
                case (state_reg)
                    IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        if (send) begin
                            shift_reg   <= {~^command, command};
                            cnt_reg     <= '0;
                            bit_cnt_reg <= '0;
                            ps2_clk_oe  <= 1'b1;
                            busy        <= 1'b1;
                            state_reg   <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (cnt_reg == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            cnt_reg    <= '0;
                            state_reg  <= START;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                            // Start bit appears while the clock is still held low.
                            if (cnt_reg == INH_DAT) begin
                                ps2_dat_oe <= 1'b1;
                            end
                        end
                    end

                    START: begin
                        if (fall) begin
                            ps2_dat_oe  <= ~shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_cnt_reg <= 4'd1;
                            cnt_reg     <= '0;
                            state_reg   <= BITS;
                        end
`ifdef PS2_TX_TIMEOUT_EN
                        else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
`endif
                    end

                    BITS: begin
                        if (fall) begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            cnt_reg     <= '0;
                            // Edge 10 releases data so the device sees the stop bit.
                            if (bit_cnt_reg == 4'd9) begin
                                ps2_dat_oe <= 1'b0;
                                state_reg  <= ACK;
                            end else begin
                                ps2_dat_oe <= ~shift_reg[0];
                                shift_reg  <= shift_reg >> 1;
                            end
                        end
`ifdef PS2_TX_TIMEOUT_EN
                        else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
`endif
                    end

                    ACK: begin
                        if (fall) begin
                            bit_cnt_reg <= 4'd11;
                            cnt_reg     <= '0;
                            if (!dat_s) begin
                                state_reg <= WAIT_IDLE;
                            end else begin
                                error     <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= IDLE;
                            end
                        end
`ifdef PS2_TX_TIMEOUT_EN
                        else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
`endif
                    end

                    WAIT_IDLE: begin
                        if (clk_s && dat_s) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end

                    default: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
